// File: rtl/load_issue_queue_pkg.sv
// Shared types for the load issue queue: tag type, per-entry record, access size codes.
// No logic; pure declarations.
// No flow control.
package load_issue_queue_pkg;

    localparam int TAG_W = 5;

    // Owned by the reservation-station side; mirrored here so the queue can compile standalone.
    typedef logic [TAG_W-1:0] RS_tag_type;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    typedef struct packed {
        logic        busy;
        logic [31:0] V1;
        logic        V1_valid;
        RS_tag_type  Q1;
        logic [31:0] V2;
        logic        V2_valid;
        RS_tag_type  Q2;
        RS_tag_type  rd_tag;
        logic [2:0]  mem_type;
    } load_entry_t;

endpackage

// File: rtl/load_operand_snoop.sv
// Tag-compare and capture of one pending operand against the CDB broadcast.
// Latency: combinational; the caller registers the result.
// Backpressure: none, the CDB cannot be stalled.
module load_operand_snoop
    import load_issue_queue_pkg::*;
(
    input  logic [31:0] opd_dat,
    input  logic        opd_vld,
    input  logic [TAG_W-1:0] opd_tag,
    input  logic        cdb_vld,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0] cdb_dat,
    output logic [31:0] cap_dat,
    output logic        cap_vld
);

    logic hit;

    assign hit     = cdb_vld && !opd_vld && (opd_tag == cdb_tag);
    assign cap_vld = opd_vld || hit;
    assign cap_dat = hit ? cdb_dat : opd_dat;

endmodule

// File: rtl/load_issue_queue.sv
// In-order load buffer: holds dispatched loads, wakes operands off the CDB, issues the oldest ready load.
// Latency: a fully-ready dispatch into an empty queue is issuable the cycle after its dispatch edge.
// Backpressure: disp_ready drops when full (even while popping); head holds until iss_ready.
module load_issue_queue
    import load_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                flush,
    input  logic                disp_valid,
    output logic                disp_ready,
    input  logic [31:0]         disp_V1,
    input  logic [31:0]         disp_V2,
    input  logic                disp_V1_valid,
    input  logic                disp_V2_valid,
    input  logic [TAG_W-1:0]    disp_Q1,
    input  logic [TAG_W-1:0]    disp_Q2,
    input  logic [TAG_W-1:0]    disp_rd_tag,
    input  logic [2:0]          disp_mem_type,
    input  logic                cdb_valid,
    input  logic [TAG_W-1:0]    cdb_tag,
    input  logic [31:0]         cdb_val,
    output logic                iss_valid,
    input  logic                iss_ready,
    output logic [31:0]         iss_V1,
    output logic [31:0]         iss_V2,
    output logic [TAG_W-1:0]    iss_rd_tag,
    output logic [2:0]          iss_mem_type,
    output logic [PTR_W:0]      count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    load_entry_t        entries [DEPTH];
    load_entry_t        head_ent;
    load_entry_t        disp_ent;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic               push;
    logic               pop;

    logic [31:0]        nxt_v1     [DEPTH];
    logic               nxt_v1_vld [DEPTH];
    logic [31:0]        nxt_v2     [DEPTH];
    logic               nxt_v2_vld [DEPTH];
    logic [31:0]        byp_v1;
    logic               byp_v1_vld;
    logic [31:0]        byp_v2;
    logic               byp_v2_vld;

    // Resident entries: only busy slots listen to the CDB.
    for (genvar g = 0; g < DEPTH; g++) begin : g_snoop
        load_operand_snoop u_snp_v1 (
            .opd_dat (entries[g].V1),
            .opd_vld (entries[g].V1_valid),
            .opd_tag (entries[g].Q1),
            .cdb_vld (cdb_valid && entries[g].busy),
            .cdb_tag (cdb_tag),
            .cdb_dat (cdb_val),
            .cap_dat (nxt_v1[g]),
            .cap_vld (nxt_v1_vld[g])
        );
        load_operand_snoop u_snp_v2 (
            .opd_dat (entries[g].V2),
            .opd_vld (entries[g].V2_valid),
            .opd_tag (entries[g].Q2),
            .cdb_vld (cdb_valid && entries[g].busy),
            .cdb_tag (cdb_tag),
            .cdb_dat (cdb_val),
            .cap_dat (nxt_v2[g]),
            .cap_vld (nxt_v2_vld[g])
        );
    end

    // Bypass on the dispatch path so a broadcast in the dispatch cycle is not lost.
    load_operand_snoop u_byp_v1 (
        .opd_dat (disp_V1),
        .opd_vld (disp_V1_valid),
        .opd_tag (disp_Q1),
        .cdb_vld (cdb_valid),
        .cdb_tag (cdb_tag),
        .cdb_dat (cdb_val),
        .cap_dat (byp_v1),
        .cap_vld (byp_v1_vld)
    );
    load_operand_snoop u_byp_v2 (
        .opd_dat (disp_V2),
        .opd_vld (disp_V2_valid),
        .opd_tag (disp_Q2),
        .cdb_vld (cdb_valid),
        .cdb_tag (cdb_tag),
        .cdb_dat (cdb_val),
        .cap_dat (byp_v2),
        .cap_vld (byp_v2_vld)
    );

    always_comb begin
        disp_ent          = '0;
        disp_ent.busy     = 1'b1;
        disp_ent.V1       = byp_v1;
        disp_ent.V1_valid = byp_v1_vld;
        disp_ent.Q1       = disp_Q1;
        disp_ent.V2       = byp_v2;
        disp_ent.V2_valid = byp_v2_vld;
        disp_ent.Q2       = disp_Q2;
        disp_ent.rd_tag   = disp_rd_tag;
        disp_ent.mem_type = disp_mem_type;
    end

    assign head_ent     = entries[head];
    assign disp_ready   = (count != FULL_CNT);
    assign iss_valid    = head_ent.busy && head_ent.V1_valid && head_ent.V2_valid;
    assign iss_V1       = head_ent.busy ? head_ent.V1       : '0;
    assign iss_V2       = head_ent.busy ? head_ent.V2       : '0;
    assign iss_rd_tag   = head_ent.busy ? head_ent.rd_tag   : '0;
    assign iss_mem_type = head_ent.busy ? head_ent.mem_type : '0;

    assign push = disp_valid && disp_ready;
    assign pop  = iss_valid && iss_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries[i].busy) begin
                    entries[i].V1       <= nxt_v1[i];
                    entries[i].V1_valid <= nxt_v1_vld[i];
                    entries[i].V2       <= nxt_v2[i];
                    entries[i].V2_valid <= nxt_v2_vld[i];
                end
            end
            // Push never targets the head slot while it is popping: push needs a free slot.
            if (pop) begin
                entries[head].busy <= 1'b0;
                head               <= head + 1'b1;
            end
            if (push) begin
                entries[tail] <= disp_ent;
                tail          <= tail + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
